// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into SHORT / LONG / REPEAT events and
// arbitrates them round-robin onto a single valid/ready event port.
module btn_event_ctrl #(
    parameter int unsigned CLK_FREQ     = 12000000,
    parameter int unsigned TICK_FREQ    = 500,
    parameter int unsigned NUM_BTN      = 2,
    parameter int unsigned LONG_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter int unsigned BW           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [BW-1:0]      evt_btn,
    output logic [1:0]         evt_code,
    output logic [NUM_BTN-1:0] evt_ovf
);

    localparam int unsigned DIV  = CLK_FREQ / TICK_FREQ;
    localparam int unsigned TW   = $clog2(DIV);
    localparam int unsigned CMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [1:0] CODE_SHORT  = 2'b01;
    localparam logic [1:0] CODE_LONG   = 2'b10;
    localparam logic [1:0] CODE_REPEAT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HELD
    } state_e;

    logic [TW-1:0]              tcnt_q, tcnt_d;
    logic                       tick;

    state_e                     state_q [NUM_BTN];
    state_e                     state_d [NUM_BTN];
    logic [NUM_BTN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_BTN-1:0]         arm_q, arm_d;
    logic [NUM_BTN-1:0]         emit;
    logic [NUM_BTN-1:0][1:0]    emit_code;

    logic [NUM_BTN-1:0]         slot_v_q, slot_v_d;
    logic [NUM_BTN-1:0][1:0]    slot_code_q, slot_code_d;

    logic                       evt_valid_q, evt_valid_d;
    logic [BW-1:0]              evt_btn_q, evt_btn_d;
    logic [1:0]                 evt_code_q, evt_code_d;
    logic [NUM_BTN-1:0]         evt_ovf_q, evt_ovf_d;
    logic [BW-1:0]              last_grant_q, last_grant_d;

    logic                       free;
    logic                       found;
    logic                       load;
    logic [BW-1:0]              win;

    always_comb begin
        tick   = (tcnt_q == TW'(DIV - 1));
        tcnt_d = tick ? '0 : tcnt_q + TW'(1);
    end

    // Per-button press timing; arm blocks a press that was already held at reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arm_d     = arm_q;
        emit      = '0;
        emit_code = '0;
        if (tick) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (!btn_i[i]) begin
                    arm_d[i] = 1'b1;
                end
                case (state_q[i])
                    S_IDLE: begin
                        if (btn_i[i] && arm_q[i]) begin
                            state_d[i] = S_PRESSED;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                    S_PRESSED: begin
                        if (!btn_i[i]) begin
                            emit[i]      = 1'b1;
                            emit_code[i] = CODE_SHORT;
                            state_d[i]   = S_IDLE;
                        end else if (cnt_q[i] + CW'(1) == CW'(LONG_TICKS)) begin
                            emit[i]      = 1'b1;
                            emit_code[i] = CODE_LONG;
                            state_d[i]   = S_HELD;
                            cnt_d[i]     = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    S_HELD: begin
                        if (!btn_i[i]) begin
                            state_d[i] = S_IDLE;
                        end else if (REPEAT_TICKS != 0) begin
                            if (cnt_q[i] + CW'(1) == CW'(REPEAT_TICKS)) begin
                                emit[i]      = 1'b1;
                                emit_code[i] = CODE_REPEAT;
                                cnt_d[i]     = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CW'(1);
                            end
                        end
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        int unsigned   idx;
        logic [BW-1:0] cand;
        idx   = 0;
        cand  = '0;
        free  = !evt_valid_q || evt_ready;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_BTN; k++) begin
            idx = 32'(last_grant_q) + 32'd1 + k;
            if (idx >= NUM_BTN) begin
                idx = idx - NUM_BTN;
            end
            cand = BW'(idx);
            if (!found && slot_v_q[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        load = free && found;

        evt_valid_d  = evt_valid_q;
        evt_btn_d    = evt_btn_q;
        evt_code_d   = evt_code_q;
        last_grant_d = last_grant_q;
        if (free) begin
            evt_valid_d = found;
            if (found) begin
                evt_btn_d    = win;
                evt_code_d   = slot_code_q[win];
                last_grant_d = win;
            end
        end

        // A slot drained in the same cycle it is rewritten keeps the new code, no overflow.
        slot_v_d    = slot_v_q;
        slot_code_d = slot_code_q;
        evt_ovf_d   = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (emit[i]) begin
                slot_v_d[i]    = 1'b1;
                slot_code_d[i] = emit_code[i];
                evt_ovf_d[i]   = slot_v_q[i] && !(load && (win == BW'(i)));
            end else if (load && (win == BW'(i))) begin
                slot_v_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q       <= '0;
            cnt_q        <= '0;
            arm_q        <= '0;
            slot_v_q     <= '0;
            slot_code_q  <= '0;
            evt_valid_q  <= 1'b0;
            evt_btn_q    <= '0;
            evt_code_q   <= '0;
            evt_ovf_q    <= '0;
            last_grant_q <= BW'(NUM_BTN - 1);
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= S_IDLE;
            end
        end else begin
            tcnt_q       <= tcnt_d;
            cnt_q        <= cnt_d;
            arm_q        <= arm_d;
            slot_v_q     <= slot_v_d;
            slot_code_q  <= slot_code_d;
            evt_valid_q  <= evt_valid_d;
            evt_btn_q    <= evt_btn_d;
            evt_code_q   <= evt_code_d;
            evt_ovf_q    <= evt_ovf_d;
            last_grant_q <= last_grant_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_btn   = evt_btn_q;
    assign evt_code  = evt_code_q;
    assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: tick every 10 clk, LONG=5, REPEAT=3,
// plus a second instance with repeat disabled.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b11;
    logic       ready = 1'b1;
    logic [1:0] btn2 = 2'b00;
    logic       ready2 = 1'b1;

    logic       valid, valid2;
    logic       ebtn, ebtn2;
    logic [1:0] code, code2;
    logic [1:0] ovf, ovf2;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         ecount = 0;
    int         base;
    int         n2 = 0;
    logic [1:0] last_code2 = 2'b00;
    logic [2:0] evq [$];
    logic       exp_ev;

    always #5 clk = ~clk;

    btn_event_ctrl #(
        .CLK_FREQ(1000), .TICK_FREQ(100), .NUM_BTN(2), .LONG_TICKS(5), .REPEAT_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_i(btn), .evt_valid(valid), .evt_ready(ready),
        .evt_btn(ebtn), .evt_code(code), .evt_ovf(ovf)
    );

    btn_event_ctrl #(
        .CLK_FREQ(1000), .TICK_FREQ(100), .NUM_BTN(2), .LONG_TICKS(5), .REPEAT_TICKS(0)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn_i(btn2), .evt_valid(valid2), .evt_ready(ready2),
        .evt_btn(ebtn2), .evt_code(code2), .evt_ovf(ovf2)
    );

    // Handshakes are stable for the whole cycle, so the falling edge sees them cleanly.
    always @(negedge clk) begin
        if (!rst && valid && ready) evq.push_back({ebtn, code});
        if (!rst && valid2 && ready2) begin
            n2++;
            last_code2 = code2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            ecount++;
        end
        #1;
    endtask

    task automatic to_tick();
        do clk_n(1); while (ecount % 10 != 0);
    endtask

    initial begin
        // Reset with both buttons held
        clk_n(3);
        chk("rst_valid", valid, 0);
        chk("rst_btn", ebtn, 0);
        chk("rst_code", code, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_valid2", valid2, 0);
        rst = 1'b0;
        ecount = 0;

        clk_n(100);
        chk("held_after_rst_q", evq.size(), 0);
        chk("held_after_rst_valid", valid, 0);

        // Release, then a fresh press resumes events
        btn = 2'b00; to_tick();
        btn = 2'b01; to_tick(); to_tick();
        btn = 2'b00; to_tick();
        clk_n(2);
        chk("resume_q", evq.size(), 1);
        chk("resume_ev", evq[0], 3'b001);

        // Short press with exact latency
        base = evq.size();
        btn = 2'b01; to_tick(); to_tick(); to_tick();
        btn = 2'b00; to_tick();
        chk("short_t1_valid", valid, 0);
        clk_n(1);
        chk("short_t2_valid", valid, 1);
        chk("short_btn", ebtn, 0);
        chk("short_code", code, 2'b01);
        clk_n(1);
        chk("short_t3_valid", valid, 0);
        to_tick(); to_tick();
        chk("short_q", evq.size(), base + 1);

        // Long + repeat on btn1
        base = evq.size();
        btn = 2'b10;
        for (int t = 1; t <= 14; t++) begin
            to_tick();
            clk_n(1);
            exp_ev = (t == 5) || (t == 8) || (t == 11) || (t == 14);
            chk("long_valid", valid, exp_ev);
            if (exp_ev) begin
                chk("long_btn", ebtn, 1);
                chk("long_code", code, (t == 5) ? 2'b10 : 2'b11);
            end
        end
        btn = 2'b00; to_tick(); clk_n(1);
        chk("long_release_valid", valid, 0);
        to_tick();
        chk("long_q", evq.size(), base + 4);
        chk("long_ev0", evq[base], 3'b110);
        chk("long_ev1", evq[base + 1], 3'b111);
        chk("long_ev3", evq[base + 3], 3'b111);

        // Simultaneous release, last grant was btn1
        btn = 2'b11; to_tick(); to_tick();
        btn = 2'b00; to_tick();
        clk_n(1);
        chk("sim1_a_valid", valid, 1);
        chk("sim1_a_btn", ebtn, 0);
        chk("sim1_a_code", code, 2'b01);
        clk_n(1);
        chk("sim1_b_valid", valid, 1);
        chk("sim1_b_btn", ebtn, 1);
        chk("sim1_b_code", code, 2'b01);
        clk_n(1);
        chk("sim1_end_valid", valid, 0);

        // Single btn0 event leaves last grant at 0
        btn = 2'b01; to_tick();
        btn = 2'b00; to_tick();
        clk_n(2);
        btn = 2'b11; to_tick(); to_tick();
        btn = 2'b00; to_tick();
        clk_n(1);
        chk("sim2_a_btn", ebtn, 1);
        chk("sim2_a_valid", valid, 1);
        clk_n(1);
        chk("sim2_b_btn", ebtn, 0);
        chk("sim2_b_valid", valid, 1);
        clk_n(1);
        chk("sim2_end_valid", valid, 0);

        // Backpressure and slot overwrite
        base = evq.size();
        ready = 1'b0;
        btn = 2'b01; to_tick();
        btn = 2'b00; to_tick();
        clk_n(1);
        chk("bp_valid", valid, 1);
        chk("bp_code", code, 2'b01);
        btn = 2'b01; to_tick();
        btn = 2'b00; to_tick();
        chk("bp_no_ovf", ovf, 0);
        chk("bp_hold_code", code, 2'b01);
        btn = 2'b01;
        repeat (5) to_tick();
        chk("bp_ovf_pulse", ovf, 2'b01);
        clk_n(1);
        chk("bp_ovf_clear", ovf, 0);
        chk("bp_hold_valid", valid, 1);
        chk("bp_hold_btn", ebtn, 0);
        chk("bp_hold_code2", code, 2'b01);
        btn = 2'b00; to_tick(); to_tick();
        chk("bp_stall_q", evq.size(), base);
        ready = 1'b1;
        clk_n(1);
        chk("bp_b2b_valid", valid, 1);
        chk("bp_b2b_code", code, 2'b10);
        clk_n(1);
        chk("bp_end_valid", valid, 0);
        chk("bp_q", evq.size(), base + 2);
        chk("bp_ev0", evq[base], 3'b001);
        chk("bp_ev1", evq[base + 1], 3'b010);

        // Repeat disabled: one LONG only
        btn2 = 2'b01;
        repeat (20) to_tick();
        btn2 = 2'b00; to_tick(); to_tick();
        chk("norep_count", n2, 1);
        chk("norep_code", last_code2, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
